fir_coef_ctrl: RTL

FIR_COEF_CTRL -- requirements
Module: fir_coef_ctrl

---
 rtl/fir_coef_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fir_coef_ctrl.sv
// rtl/fir_coef_ctrl.sv - coefficient load / sample gating controller for a FIR
// Optional warm-up threshold: define FIR_COEF_CTRL_WARMUP_EN.
module fir_coef_ctrl #(
   parameter int NTAP = 27,
   parameter int CW   = 9,
   parameter int LAT  = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_start,
   input  logic                 coef_valid,
   input  logic [CW-1:0]        coef_data,
   output logic                 coef_ready,
   input  logic                 s_valid,
   input  logic [3:0]           s_mag,
   output logic                 s_ready,
   output logic [3:0]           fir_mag,
   output logic                 fir_en_n,
   output logic                 fir_clr,
   output logic [NTAP*CW-1:0]   h_buf,
   output logic                 o_valid,
   output logic                 load_done
);

   localparam int IW = (NTAP > 1) ? $clog2(NTAP) : 1;
`ifdef FIR_COEF_CTRL_WARMUP_EN
   localparam int THR = LAT + NTAP - 1;
`else
   localparam int THR = LAT;
`endif
   localparam logic [5:0] THR_C = 6'(THR);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_RUN} state_t;

   state_t               state_q, state_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [5:0]           acc_cnt_q, acc_cnt_d;
   logic [NTAP*CW-1:0]   shadow_q, shadow_d;
   logic [NTAP*CW-1:0]   h_buf_q, h_buf_d;
   logic                 o_valid_q, o_valid_d;
   logic                 load_done_q, load_done_d;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      acc_cnt_d   = acc_cnt_q;
      shadow_d    = shadow_q;
      h_buf_d     = h_buf_q;
      o_valid_d   = 1'b0;
      load_done_d = 1'b0;
      coef_ready  = 1'b0;
      s_ready     = 1'b0;
      fir_en_n    = 1'b1;
      fir_clr     = 1'b0;
      fir_mag     = s_mag;

      case (state_q)
         S_IDLE: begin
            if (load_start) state_d = S_LOAD;
         end
         S_LOAD: begin
            coef_ready = 1'b1;
            if (coef_valid) begin
               shadow_d[int'(idx_q)*CW +: CW] = coef_data;
               // The final beat is folded into the commit on the same edge.
               if (idx_q == IW'(NTAP-1)) begin
                  h_buf_d     = shadow_d;
                  idx_d       = '0;
                  load_done_d = 1'b1;
                  state_d     = S_FLUSH;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         S_FLUSH: begin
            fir_clr   = 1'b1;
            acc_cnt_d = '0;
            state_d   = S_RUN;
         end
         S_RUN: begin
            s_ready  = 1'b1;
            fir_en_n = ~s_valid;
            if (s_valid) begin
               acc_cnt_d = (acc_cnt_q == 6'd63) ? acc_cnt_q : acc_cnt_q + 6'd1;
               o_valid_d = (acc_cnt_d >= THR_C);
            end
            if (load_start) state_d = S_LOAD;
         end
         default: state_d = S_IDLE;
      endcase

      // Handshake outputs are forced quiet while reset is held.
      if (rst) begin
         coef_ready = 1'b0;
         s_ready    = 1'b0;
         fir_en_n   = 1'b1;
         fir_clr    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         acc_cnt_q   <= '0;
         shadow_q    <= '0;
         h_buf_q     <= '0;
         o_valid_q   <= 1'b0;
         load_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         acc_cnt_q   <= acc_cnt_d;
         shadow_q    <= shadow_d;
         h_buf_q     <= h_buf_d;
         o_valid_q   <= o_valid_d;
         load_done_q <= load_done_d;
      end
   end

   assign h_buf     = h_buf_q;
   assign o_valid   = o_valid_q;
   assign load_done = load_done_q;

endmodule
